// File: rtl/disp_scan_ctrl_if.sv
// Bus bundle between the display scan controller and whatever drives it.
// Optional feature macro: DISP_BLANK_EN adds the per-digit blanking mask.
interface disp_scan_ctrl_if;
  logic       en;
  logic       load;
  logic [7:0] d0;
  logic [7:0] d1;
  logic [7:0] d2;
  logic [7:0] d3;
  logic [7:0] q0;
  logic [7:0] q1;
  logic [7:0] q2;
  logic [7:0] q3;
  logic [1:0] sel;
  logic [3:0] an;
  logic       tick;
  logic       pending;
`ifdef DISP_BLANK_EN
  logic [3:0] blank;
`endif

  // Side that supplies scan control and new digit data
  modport master (
`ifdef DISP_BLANK_EN
    output blank,
`endif
    output en, load, d0, d1, d2, d3,
    input  q0, q1, q2, q3, sel, an, tick, pending
  );

  // The scan controller itself
  modport slave (
`ifdef DISP_BLANK_EN
    input  blank,
`endif
    input  en, load, d0, d1, d2, d3,
    output q0, q1, q2, q3, sel, an, tick, pending
  );
endinterface

// File: rtl/disp_scan_ctrl.sv
// Display scan controller: prescaled 2-bit digit select, registered active-low
// anodes and four double-buffered digit registers that only change at a frame
// boundary (sel 3->0) while the display is lit.
// Optional feature macro: DISP_BLANK_EN (per-digit anode blanking mask).
module disp_scan_ctrl #(
  parameter int CLK_DIV = 100000
) (
  input  logic             clk,
  input  logic             rst,
  disp_scan_ctrl_if.slave  bus
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      sel_q, sel_d;
  logic [3:0]      an_q, an_d;
  logic            tick_q, tick_d;
  logic            pending_q, pending_d;
  logic [3:0][7:0] q_q, q_d;
  logic [3:0][7:0] shadow_q, shadow_d;

  logic            step;
  logic            boundary;
  logic [3:0][7:0] d_in;

  assign d_in = {bus.d3, bus.d2, bus.d1, bus.d0};

  // Prescaler, digit select, step pulse and anode pattern for the next cycle
  always_comb begin
    step     = bus.en && (cnt_q == CNT_MAX);
    boundary = step && (sel_q == 2'd3);
    cnt_d    = cnt_q;
    if (bus.en) begin
      cnt_d = step ? '0 : cnt_q + CW'(1);
    end
    sel_d  = step ? sel_q + 2'd1 : sel_q;
    tick_d = step;
    an_d   = bus.en ? ~(4'b0001 << sel_d) : 4'b1111;
`ifdef DISP_BLANK_EN
    an_d   = an_d | bus.blank;
`endif
  end

  // Shadow capture and commit; lit display commits only on a frame boundary
  always_comb begin
    q_d       = q_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (bus.en) begin
      if (boundary) begin
        if (bus.load) begin
          q_d       = d_in;
          shadow_d  = d_in;
          pending_d = 1'b0;
        end else if (pending_q) begin
          q_d       = shadow_q;
          pending_d = 1'b0;
        end
      end else if (bus.load) begin
        shadow_d  = d_in;
        pending_d = 1'b1;
      end
    end else begin
      if (bus.load) begin
        q_d       = d_in;
        pending_d = 1'b0;
      end else if (pending_q) begin
        q_d       = shadow_q;
        pending_d = 1'b0;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      sel_q     <= 2'd0;
      an_q      <= 4'b1111;
      tick_q    <= 1'b0;
      pending_q <= 1'b0;
      q_q       <= '0;
      shadow_q  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      an_q      <= an_d;
      tick_q    <= tick_d;
      pending_q <= pending_d;
      q_q       <= q_d;
      shadow_q  <= shadow_d;
    end
  end

  assign bus.q0      = q_q[0];
  assign bus.q1      = q_q[1];
  assign bus.q2      = q_q[2];
  assign bus.q3      = q_q[3];
  assign bus.sel     = sel_q;
  assign bus.an      = an_q;
  assign bus.tick    = tick_q;
  assign bus.pending = pending_q;

endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Display scan controller that feeds the 4:1 8-bit digit multiplexer. A programmable prescaler steps a 2-bit digit select through 0→1→2→3→0. The controller drives the active-low digit anodes in lockstep with the select and holds four 8-bit digit registers that are wired to the mux data inputs. New digit values are double-buffered and committed only at a frame boundary, so a displayed frame never mixes old and new data.

## Interface
- CLK_DIV, 100000, number of clock cycles per digit step; legal range 1..2^24; counter width is $clog2(CLK_DIV) (minimum 1).
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  scan enable.
- load  in  1  single-cycle strobe; capture d0..d3.
- d0, d1, d2, d3  in  8 each  new digit data.
- q0, q1, q2, q3  out  8 each  committed digit registers, wired to mux in0..in3.
- sel  out  2  digit select, wired to mux sel2.
- an  out  4  anode enables, active-low; bit i is digit i.
- tick  out  1  one-cycle pulse in the cycle after sel advances.
- pending  out  1  shadow data captured but not yet committed.

## Operation
- Reset (rst=1 at an edge): div_cnt=0, sel=0, an=4'b1111, tick=0, pending=0, q0..q3=8'h00, shadow0..3=8'h00. Reset applied mid-frame discards any pending data.
- Prescaler:
  - When en=1, div_cnt counts 0..CLK_DIV-1, then wraps to 0.
  - A step occurs at an edge where en=1 and div_cnt==CLK_DIV-1.
  - On a step, sel increments mod 4 (3→0) and tick is set to 1 for one cycle.
- en=0: div_cnt and sel hold, tick=0, an=4'b1111.
- Anodes are registered: an <= en ? ~(4'b0001 << sel_next) : 4'b1111, where sel_next is the value sel takes on the same edge. This keeps an and sel coherent on every cycle.
- Frame boundary: a step where sel goes from 3 to 0.
- Load handling:
  - load=1 with en=1, not at a boundary: shadow0..3 <= d0..d3; pending <= 1; q unchanged.
  - Repeated load while pending: shadows are overwritten; the last load wins.
  - At a boundary edge with pending=1 and load=0: q <= shadow; pending <= 0.
  - load=1 at the boundary edge: q <= d0..d3 directly; shadow <= d; pending <= 0.
  - load=1 with en=0: q <= d0..d3 on the next edge; pending stays 0. The display is dark, so there is no tearing risk.
  - en dropping while pending=1: pending and the shadows are held. On the first edge with en=0 and pending=1, q <= shadow and pending <= 0.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Step latency: the first step occurs CLK_DIV edges after en rises with div_cnt=0.
- An is valid (one-hot low) one edge after en rises. It returns to 4'b1111 one edge after en falls.
- A load commits after at most 4·CLK_DIV cycles (one full frame) while en=1, or 1 cycle while en=0.
- With CLK_DIV=1, a step occurs on every enabled edge; tick stays high continuously.

## Configuration
- DISP_BLANK_EN: compiles in an extra input, blank  in  4, a per-digit blanking mask.
  - With the macro defined: any an bit whose blank bit is 1 is forced to 1. The scan sequence, sel and tick are unaffected.
  - Without it: the port does not exist and an follows the rules above unmasked.

## Test plan
- Reset: hold rst=1 for 2 cycles with en=1 and load=1 → sel=0, an=4'b1111, tick=0, pending=0, q0..q3=8'h00.
- Scan, CLK_DIV=4, en rises after reset:
  - next edge an=4'b1110;
  - at the 4th edge sel=1, an=4'b1101, tick=1 for exactly one cycle;
  - sel then follows 2,3,0 every 4 cycles, with an=1011, 0111, 1110.
- Deferred load, CLK_DIV=4: load with d0..d3=8'h11,8'h22,8'h33,8'h44 while sel=1 → pending=1 and q unchanged until the 3→0 edge, then q0..q3=8'h11..8'h44 and pending=0.
- Coincident and overwrite cases:
  - load with d=8'hA5 on all digits at the 3→0 edge → q=8'hA5 at that edge, pending=0;
  - two loads (8'h01, then 8'h02) within one frame → q=8'h02 at the boundary.
- en=0 behaviour:
  - load with d=8'h5A → q=8'h5A next edge, an=4'b1111, sel frozen;
  - pending=1, then en dropped → q committed on the next edge.
- DISP_BLANK_EN: blank=4'b0100, en=1 → at sel=2 an=4'b1111; at sel=1 an=4'b1101; tick timing identical to the unmasked run.
